// File: rtl/ifm_reader.sv
// Input feature-map reader: fetches a frame over AXI4 read bursts into a
// first-word fall-through FIFO and streams it out with a valid/ready handshake.
module ifm_reader #(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int W_ID      = 4,
    parameter int BURST_LEN = 32,
    parameter int DEPTH     = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [W_ADDR-1:0] read_address,
    input  logic [23:0]       frame_size,
    output logic [W_DATA-1:0] o_pix,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic              o_layer_done,
    output logic              o_err,
    // AR channel
    output logic [W_ID-1:0]   M_ARID,
    output logic [W_ADDR-1:0] M_ARADDR,
    output logic [7:0]        M_ARLEN,
    output logic [2:0]        M_ARSIZE,
    output logic [1:0]        M_ARBURST,
    output logic [1:0]        M_ARLOCK,
    output logic [3:0]        M_ARCACHE,
    output logic [2:0]        M_ARPROT,
    output logic [3:0]        M_ARREGION,
    output logic [3:0]        M_ARQOS,
    output logic              M_ARVALID,
    input  logic              M_ARREADY,
    // R channel
    input  logic [W_ID-1:0]   M_RID,
    input  logic [W_DATA-1:0] M_RDATA,
    input  logic [1:0]        M_RRESP,
    input  logic              M_RLAST,
    input  logic              M_RVALID,
    output logic              M_RREADY
);

    localparam int W_PTR  = $clog2(DEPTH);
    localparam int W_CNT  = $clog2(DEPTH + 1);
    localparam int W_BEAT = $clog2(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W_ADDR-1:0]   r_base;
    logic [16:0]         r_nblk;
    logic [16:0]         r_blk_cnt;
    logic [W_BEAT-1:0]   r_beat_cnt;
    logic                r_err;

    logic [W_DATA-1:0]   r_mem [DEPTH];
    logic [W_PTR-1:0]    r_wr_ptr;
    logic [W_PTR-1:0]    r_rd_ptr;
    logic [W_CNT-1:0]    r_count;

    logic                w_start_ok;
    logic                w_beat;
    logic                w_last_beat;
    logic                w_empty;
    logic                w_rd;
    logic [W_CNT-1:0]    w_free;
    logic [W_ADDR-1:0]   w_off;
    logic                w_unused;

    assign M_ARID     = '0;
    assign M_ARLEN    = 8'(BURST_LEN - 1);
    assign M_ARSIZE   = 3'd2;
    assign M_ARBURST  = 2'd1;
    assign M_ARLOCK   = '0;
    assign M_ARCACHE  = '0;
    assign M_ARPROT   = '0;
    assign M_ARREGION = '0;
    assign M_ARQOS    = '0;

    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_beat      = (r_state == S_DATA) && M_RVALID;
    assign w_last_beat = (r_beat_cnt == W_BEAT'(BURST_LEN - 1));
    assign w_empty     = (r_count == '0);
    assign w_rd        = !w_empty && i_rdy;
    assign w_free      = W_CNT'(DEPTH) - r_count;
    // Each burst covers 128 bytes; the sum wraps at the address width.
    assign w_off       = W_ADDR'({r_blk_cnt, 7'b0});
    assign w_unused    = ^{M_RID, frame_size[6:0]};

    assign o_vld        = !w_empty;
    assign o_pix        = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_layer_done = (r_state == S_DONE) && w_empty;
    assign o_err        = r_err;

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next    = r_state;
        M_ARVALID = 1'b0;
        M_ARADDR  = '0;
        M_RREADY  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CHECK;
            end
            S_CHECK: begin
                // Only request a burst once the FIFO can absorb all of it.
                if (r_blk_cnt == r_nblk)
                    w_next = S_DONE;
                else if (w_free >= W_CNT'(BURST_LEN))
                    w_next = S_ADDR;
            end
            S_ADDR: begin
                M_ARVALID = 1'b1;
                M_ARADDR  = r_base + w_off;
                if (M_ARREADY) w_next = S_DATA;
            end
            S_DATA: begin
                M_RREADY = 1'b1;
                if (w_beat && w_last_beat) w_next = S_CHECK;
            end
            S_DONE: begin
                if (start) w_next = S_CHECK;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_nblk     <= '0;
            r_blk_cnt  <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_base     <= read_address;
                r_nblk     <= frame_size[23:7];
                r_blk_cnt  <= '0;
                r_beat_cnt <= '0;
                r_err      <= 1'b0;
            end else if (w_beat) begin
                if (w_last_beat) begin
                    r_beat_cnt <= '0;
                    r_blk_cnt  <= r_blk_cnt + 17'd1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                // A misplaced RLAST or a non-OKAY response is recorded but the
                // burst length stays fixed by the beat counter.
                if ((M_RLAST != w_last_beat) || (M_RRESP != 2'b00))
                    r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_beat)
                r_wr_ptr <= (r_wr_ptr == W_PTR'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= (r_rd_ptr == W_PTR'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_beat, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers and count alone, and o_pix is masked while empty.
    always_ff @(posedge clk) begin
        if (w_beat) r_mem[r_wr_ptr] <= M_RDATA;
    end

endmodule
